// File: rtl/iiitb_brg_gen.sv
// Baud-rate generator: oversample tick, bit tick and 50% baud clock.
// Rate comes from four presets or a custom divisor; switches land on bit edges.
module iiitb_brg_gen #(
    parameter int DIV_W    = 16,
    parameter int OSR      = 16,
    parameter int BASE_DIV = 68
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic             cust_en,
    input  logic             div_wr,
    input  logic [DIV_W-1:0] div_in,
    output logic             tick_os,
    output logic             tick_bit,
    output logic             clkout,
    output logic             pend,
    output logic [DIV_W-1:0] div_act
);

    localparam int OW = (OSR > 2) ? $clog2(OSR) : 1;

    localparam logic [DIV_W-1:0] P_X1  = DIV_W'(BASE_DIV);
    localparam logic [DIV_W-1:0] P_X3  = DIV_W'(BASE_DIV * 3);
    localparam logic [DIV_W-1:0] P_X6  = DIV_W'(BASE_DIV * 6);
    localparam logic [DIV_W-1:0] P_X12 = DIV_W'(BASE_DIV * 12);
    localparam logic [DIV_W-1:0] D_MIN = DIV_W'(2);

    localparam logic [OW-1:0] O_HALF = OW'(OSR / 2);
    localparam logic [OW-1:0] O_LAST = OW'(OSR - 1);

    if ((longint'(BASE_DIV) * 12) >= (longint'(1) << DIV_W)) begin : g_div_chk
        $error("BASE_DIV*12 does not fit in DIV_W bits");
    end

    if ((OSR < 2) || (OSR % 2 != 0)) begin : g_osr_chk
        $error("OSR must be even and at least 2");
    end

    logic [DIV_W-1:0] cust;
    logic [DIV_W-1:0] tgt;
    logic [DIV_W-1:0] pcnt;
    logic [OW-1:0]    ocnt;
    logic             run;

    always_comb begin
        tgt = P_X1;
        if (cust_en) begin
            tgt = cust;
        end else begin
            unique case (sel)
                2'b00: tgt = P_X1;
                2'b01: tgt = P_X3;
                2'b10: tgt = P_X6;
                2'b11: tgt = P_X12;
                default: tgt = P_X1;
            endcase
        end
    end

    // run delays counting by one edge so the first tick lands D cycles
    // after the first enabled edge, matching the steady-state spacing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cust     <= P_X1;
            div_act  <= P_X1;
            pcnt     <= '0;
            ocnt     <= '0;
            run      <= 1'b0;
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
            clkout   <= 1'b0;
            pend     <= 1'b0;
        end else begin
            pend     <= (tgt != div_act);
            tick_os  <= 1'b0;
            tick_bit <= 1'b0;
            if (div_wr) begin
                cust <= (div_in < D_MIN) ? D_MIN : div_in;
            end
            if (!en) begin
                run     <= 1'b0;
                pcnt    <= '0;
                ocnt    <= '0;
                clkout  <= 1'b0;
                div_act <= tgt;
            end else if (!run) begin
                run <= 1'b1;
            end else if (pcnt == div_act - 1'b1) begin
                pcnt    <= '0;
                tick_os <= 1'b1;
                if (ocnt == '0) begin
                    clkout <= 1'b1;
                end
                if (ocnt == O_HALF) begin
                    clkout <= 1'b0;
                end
                if (ocnt == O_LAST) begin
                    ocnt     <= '0;
                    tick_bit <= 1'b1;
                    div_act  <= tgt;
                end else begin
                    ocnt <= ocnt + 1'b1;
                end
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iiitb_brg_gen.sv
// Scoreboard bench for iiitb_brg_gen: expected tick events are queued by
// the stimulus and matched against the DUT by a negedge monitor.
module tb_iiitb_brg_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic [1:0]  sel;
    logic        cust_en;
    logic        div_wr;
    logic [15:0] div_in;
    logic        tick_os;
    logic        tick_bit;
    logic        clkout;
    logic        pend;
    logic [15:0] div_act;

    iiitb_brg_gen dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .sel      (sel),
        .cust_en  (cust_en),
        .div_wr   (div_wr),
        .div_in   (div_in),
        .tick_os  (tick_os),
        .tick_bit (tick_bit),
        .clkout   (clkout),
        .pend     (pend),
        .div_act  (div_act)
    );

    typedef struct {
        int cyc;
        bit bt;
        bit ck;
        int dact;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   mon_checks = 0;
    int   mon_fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (tick_os) begin
            mon_checks++;
            if (q.size() == 0) begin
                mon_fails++;
                $display("FAIL unexpected_tick cyc=%0d got tick_os=1 want none", cyc);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc) begin
                    mon_fails++;
                    $display("FAIL tick_time got=%0d want=%0d", cyc, e.cyc);
                end
                mon_checks++;
                if (tick_bit != e.bt) begin
                    mon_fails++;
                    $display("FAIL tick_bit cyc=%0d got=%0b want=%0b", cyc, tick_bit, e.bt);
                end
                mon_checks++;
                if (clkout != e.ck) begin
                    mon_fails++;
                    $display("FAIL clkout cyc=%0d got=%0b want=%0b", cyc, clkout, e.ck);
                end
                mon_checks++;
                if (int'(div_act) != e.dact) begin
                    mon_fails++;
                    $display("FAIL tick_div_act cyc=%0d got=%0d want=%0d", cyc, div_act, e.dact);
                end
            end
        end else if (tick_bit) begin
            mon_checks++;
            mon_fails++;
            $display("FAIL lone_tick_bit cyc=%0d got tick_bit=1 want 0", cyc);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    // Queue ticks n0..n1 spaced d apart, the first one d cycles after edge k.
    task automatic push_run(input int k, input int d, input int n0,
                            input int n1, input int dact);
        exp_t e;
        for (int n = n0; n <= n1; n++) begin
            e.cyc  = k + d * (n - n0 + 1);
            e.bt   = ((n % 16) == 0);
            e.ck   = (((n - 1) % 16) < 8);
            e.dact = dact;
            q.push_back(e);
        end
    endtask

    task automatic wait_q(input int n, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (q.size() <= n) return;
        end
        checks++;
        failures++;
        $display("FAIL %s timeout got_pending=%0d want=%0d", nm, q.size(), n);
        q.delete();
    endtask

    task automatic enable(output int k);
        @(negedge clk);
        en = 1'b1;
        k = cyc + 1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        reset   = 1'b0;
        en      = 1'b1;
        sel     = 2'b00;
        cust_en = 1'b0;
        div_wr  = 1'b0;
        div_in  = 16'd0;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sel     = 2'(i);
            cust_en = i[0];
            div_wr  = i[1];
            div_in  = 16'(i + 3);
        end
        @(negedge clk);
        chk("rst_tick_os", int'(tick_os), 0);
        chk("rst_tick_bit", int'(tick_bit), 0);
        chk("rst_clkout", int'(clkout), 0);
        chk("rst_pend", int'(pend), 0);
        chk("rst_div_act", int'(div_act), 68);
        sel     = 2'b00;
        cust_en = 1'b0;
        div_wr  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        k = cyc + 1;

        push_run(k, 68, 1, 48, 68);
        wait_q(0, 4000, "preset00");
        en = 1'b0;
        @(negedge clk);
        chk("en_off_clkout", int'(clkout), 0);
        chk("en_off_tick", int'(tick_os), 0);

        sel = 2'b01;
        idle(3);
        chk("p01_div_act", int'(div_act), 204);
        chk("p01_pend", int'(pend), 0);
        enable(k);
        push_run(k, 204, 1, 16, 204);
        wait_q(0, 4000, "preset01");
        en = 1'b0;

        sel = 2'b11;
        idle(3);
        chk("p11_div_act", int'(div_act), 816);
        enable(k);
        push_run(k, 816, 1, 16, 816);
        wait_q(0, 14000, "preset11");
        en = 1'b0;

        sel = 2'b00;
        idle(3);
        chk("sw_start_div", int'(div_act), 68);
        enable(k);
        push_run(k, 68, 1, 15, 68);
        push_run(k + 1020, 68, 16, 16, 816);
        push_run(k + 1088, 816, 17, 32, 816);
        wait_q(27, 2000, "sw_tick5");
        sel = 2'b11;
        @(negedge clk);
        chk("sw_pend_set", int'(pend), 1);
        chk("sw_div_hold", int'(div_act), 68);
        wait_q(16, 2000, "sw_tick16");
        chk("sw_pend_at_bit", int'(pend), 1);
        chk("sw_div_new", int'(div_act), 816);
        @(negedge clk);
        chk("sw_pend_clr", int'(pend), 0);
        wait_q(0, 16000, "sw_new_rate");
        en = 1'b0;

        cust_en = 1'b1;
        div_in  = 16'd300;
        div_wr  = 1'b1;
        @(negedge clk);
        div_in  = 16'd40;
        @(negedge clk);
        div_wr  = 1'b0;
        idle(2);
        chk("cust_last_wins", int'(div_act), 40);
        div_in = 16'd1;
        div_wr = 1'b1;
        @(negedge clk);
        div_wr = 1'b0;
        idle(2);
        chk("cust_min_2", int'(div_act), 2);
        enable(k);
        push_run(k, 2, 1, 64, 2);
        wait_q(0, 500, "cust_run");
        en = 1'b0;

        cust_en = 1'b0;
        sel     = 2'b00;
        idle(3);
        enable(k);
        push_run(k, 68, 1, 5, 68);
        wait_q(0, 1000, "intr_run");
        for (int i = 0; i < 1000 && cyc < k + 407; i++) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("intr_no_tick", int'(tick_os), 0);
        chk("intr_clkout", int'(clkout), 0);
        idle(5);
        enable(k);
        push_run(k, 68, 1, 2, 68);
        wait_q(0, 1000, "restart");
        idle(10);
        chk("pre_rst_clkout", int'(clkout), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_clkout", int'(clkout), 0);
        chk("async_rst_div", int'(div_act), 68);
        chk("async_rst_tick", int'(tick_os), 0);
        en = 1'b0;
        idle(3);
        reset = 1'b1;
        idle(3);
        chk("queue_empty", q.size(), 0);

        checks   += mon_checks;
        failures += mon_fails;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
